lzc_normalizer: RTL and testbench

//  Consumer end of the leading-one finder: takes a word plus its leading-zero count (0..32) and

---
 rtl/lzc_normalizer.sv | 106 ++++++++++
 tb/tb_lzc_normalizer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_normalizer.sv
// Normaliser after leading-one detection: left-shifts a word by its leading-zero count
// using an iterative log-shifter (one binary stage per clock) with valid/ready on both sides.
module lzc_normalizer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  lzc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  lzc_out,
  output logic              zero_out,
  output logic              norm_ok
);

  localparam int NSTG   = $clog2(DATA_W);
  localparam int STEP_W = $clog2(NSTG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_lzc;
  logic                r_zero;

  logic                w_zero_in;
  logic                w_last;
  logic [STEP_W-1:0]   w_idx;
  logic [DATA_W-1:0]   w_shifted;

  // One log-shifter stage: shift by 2^idx when enabled, zeros enter at the LSB.
  function automatic logic [DATA_W-1:0] stage_shift(input logic [DATA_W-1:0] d,
                                                   input logic [STEP_W-1:0] idx,
                                                   input logic              en);
    logic [DATA_W-1:0] res;
    res = d;
    if (en) res = d << (32'd1 << idx);
    return res;
  endfunction

  // Counts of DATA_W and above (including out-of-range codes) mean an all-zero word.
  assign w_zero_in = ({1'b0, lzc_in} >= (CNT_W + 1)'(DATA_W));
  assign w_idx     = STEP_W'(NSTG - 1) - r_step;
  assign w_last    = (r_step == STEP_W'(NSTG - 1));
  assign w_shifted = stage_shift(r_data, w_idx, r_lzc[w_idx]);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign data_out  = r_data;
  assign lzc_out   = r_lzc;
  assign zero_out  = r_zero;
  assign norm_ok   = r_data[DATA_W-1] & ~r_zero;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = w_zero_in ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Capture on acceptance, then one shifter stage per SHIFT cycle, largest stage first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step <= '0;
      r_data <= '0;
      r_lzc  <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data <= w_zero_in ? '0 : data_in;
            r_lzc  <= lzc_in;
            r_zero <= w_zero_in;
            r_step <= '0;
          end
        end
        S_SHIFT: begin
          r_data <= w_shifted;
          r_step <= r_step + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer: directed cases plus randomized traffic, every cycle compared
// against a transaction-level model (shift-by-count result and fixed latency countdown).
module tb_lzc_normalizer;

  localparam int DW  = 32;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [5:0]  lzc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [5:0]  lzc_out;
  logic        zero_out;
  logic        norm_ok;

  logic        rand_ordy;
  logic        dir_ordy;
  logic        r_rand;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic        m_busy;
  int          m_wait;
  logic [31:0] m_data;
  logic [5:0]  m_lzc;
  logic        m_zero;

  assign out_ready = rand_ordy ? r_rand : dir_ordy;

  lzc_normalizer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .lzc_in   (lzc_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .lzc_out  (lzc_out),
    .zero_out (zero_out),
    .norm_ok  (norm_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] norm_ref(input logic [31:0] d, input logic [5:0] l);
    if (int'(l) >= DW) return 32'd0;
    return d << l;
  endfunction

  function automatic logic [5:0] clz(input logic [31:0] d);
    for (int i = 31; i >= 0; i--) if (d[i]) return 6'(31 - i);
    return 6'd32;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: result is data<<lzc (or zero), ready after a fixed latency.
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_wait <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_wait <= (int'(lzc_in) >= DW) ? 0 : LAT;
        m_data <= norm_ref(data_in, lzc_in);
        m_lzc  <= lzc_in;
        m_zero <= (int'(lzc_in) >= DW);
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) r_rand <= 1'($urandom_range(0, 1));

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
      if (m_busy && m_wait == 0) begin
        chk("data_out", data_out, m_data);
        chk("lzc_out", 32'(lzc_out), 32'(m_lzc));
        chk("zero_out", 32'(zero_out), 32'(m_zero));
        chk("norm_ok", 32'(norm_ok), 32'(!m_zero && m_data[31]));
      end
    end
  end

  // Present a word and hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] d, input logic [5:0] l);
    int t;
    in_valid = 1'b1;
    data_in  = d;
    lzc_in   = l;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stuck 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic release_out();
    dir_ordy = 1'b1;
    @(negedge clk);
    dir_ordy = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    lzc_in    = '0;
    rand_ordy = 1'b0;
    dir_ordy  = 1'b0;

    chk("pin_t1", norm_ref(32'h0000_1234, 6'd19), 32'h91A0_0000);
    chk("pin_t4", norm_ref(32'h0000_0001, 6'd31), 32'h8000_0000);
    chk("pin_zero", norm_ref(32'hDEAD_BEEF, 6'd40), 32'h0);
    chk("pin_clz", 32'(clz(32'h00F0_0000)), 32'd8);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_lzc_out", 32'(lzc_out), 32'd0);
    chk("rst_zero_out", 32'(zero_out), 32'd0);

    // T1
    send(32'h0000_1234, 6'd19);
    wait_valid("t1_latency", LAT);
    chk("t1_data", data_out, 32'h91A0_0000);
    chk("t1_norm_ok", 32'(norm_ok), 32'd1);
    chk("t1_zero", 32'(zero_out), 32'd0);
    release_out();

    // T2
    send(32'h8000_0001, 6'd0);
    wait_valid("t2_latency", LAT);
    chk("t2_data", data_out, 32'h8000_0001);
    release_out();

    // T3
    send(32'h0000_0000, 6'd32);
    wait_valid("t3_latency", 0);
    chk("t3_zero", 32'(zero_out), 32'd1);
    chk("t3_data", data_out, 32'd0);
    chk("t3_norm_ok", 32'(norm_ok), 32'd0);
    release_out();

    // T4 with backpressure
    send(32'h0000_0001, 6'd31);
    wait_valid("t4_latency", LAT);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_data", data_out, 32'h8000_0000);
      chk("t4_hold_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    release_out();
    chk("t4_back_idle", 32'(in_ready), 32'd1);

    // T5 inconsistent count
    send(32'h0000_0001, 6'd4);
    wait_valid("t5_latency", LAT);
    chk("t5_data", data_out, 32'h0000_0010);
    chk("t5_norm_ok", 32'(norm_ok), 32'd0);
    release_out();

    // T6 reset mid-shift
    send(32'h0000_1234, 6'd19);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", data_out, 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    send(32'h00F0_0000, 6'd8);
    wait_valid("t6_latency", LAT);
    chk("t6_new_data", data_out, 32'hF000_0000);
    release_out();

    // randomized traffic with random backpressure
    rand_ordy = 1'b1;
    for (int k = 0; k < 150; k++) begin
      logic [31:0] d;
      logic [5:0]  l;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = $urandom;
      d = d >> $urandom_range(0, 32);
      case ($urandom_range(0, 3))
        0, 1:    l = clz(d);
        2:       l = 6'($urandom_range(0, 63));
        default: l = 6'($urandom_range(0, 31));
      endcase
      send(d, l);
    end
    rand_ordy = 1'b0;
    dir_ordy  = 1'b1;
    begin
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("drain", 32'(in_ready), 32'd1);
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
